// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings, slave FSM states and DMA descriptor offsets
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [7:0] DESC_SRC  = 8'hA0;
    localparam logic [7:0] DESC_DST  = 8'hA4;
    localparam logic [7:0] DESC_SIZE = 8'hA8;
    localparam logic [7:0] DESC_CTRL = 8'hAC;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ERR1,
        S_ERR2
    } slave_state_e;

endpackage

// File: rtl/ahb_byte_ram.sv
// rtl/ahb_byte_ram.sv - four byte-lane arrays, synchronous lane-enabled write, asynchronous word read
module ahb_byte_ram #(
    parameter int WORDS = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [3:0]       wr_lane,
    input  logic [31:0]      wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_data
);

    logic [7:0] lanes [4][WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_lane[i]) begin
                lanes[i][wr_idx] <= wr_data[8*i +: 8];
            end
        end
    end

    assign rd_data = {lanes[3][rd_idx], lanes[2][rd_idx], lanes[1][rd_idx], lanes[0][rd_idx]};

endmodule

// File: rtl/ahb_dma_slave_mem.sv
// rtl/ahb_dma_slave_mem.sv - AHB-Lite byte-strobed memory slave with wait states, ERROR responses
// and the requesting side of a DMAC request/acknowledge handshake
module ahb_dma_slave_mem
    import ahb_pkg::*;
#(
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic        HREADYIN,
    input  logic [31:0] HWDATA,
    input  logic [3:0]  WSTRB,
    output logic [31:0] HRDATA,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    input  logic        dma_trigger,
    input  logic        req_ack,
    output logic        dma_req,
    output logic [7:0]  err_count
);

    localparam int ADDR_W = $clog2(MEM_DEPTH);
    localparam int IDX_W  = ADDR_W - 2;
    localparam int WORDS  = MEM_DEPTH / 4;
    localparam logic [3:0] WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    slave_state_e     state;
    logic             pend;
    logic             write_q;
    logic [IDX_W-1:0] idx_q;
    logic [3:0]       wait_cnt;

    logic             accept;
    logic             in_range;
    logic             ram_wr;
    logic [3:0]       wr_lane;
    logic [IDX_W-1:0] addr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [31:0]      ram_rd;
    logic [31:0]      fwd_rd;
    logic             unused_bits;

    assign accept   = HSEL & HREADYIN & HTRANS[1] & HREADYOUT;
    assign addr_idx = HADDR[ADDR_W-1:2];
    // Range check uses the whole address so aliases above MEM_DEPTH are rejected, not wrapped.
    assign in_range = HADDR[31:2] < 30'(WORDS);
    assign ram_wr   = pend & write_q & ~rst;
    assign wr_lane  = ram_wr ? WSTRB : 4'b0000;
    assign rd_idx   = (state == S_WAIT) ? idx_q : addr_idx;

    assign unused_bits = &{1'b0, HSIZE, HADDR[1:0], HTRANS[0]};

    ahb_byte_ram #(
        .WORDS (WORDS),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk     (clk),
        .wr_idx  (idx_q),
        .wr_lane (wr_lane),
        .wr_data (HWDATA),
        .rd_idx  (rd_idx),
        .rd_data (ram_rd)
    );

    // A write completing this cycle is merged into a read being sampled in the same cycle.
    always_comb begin
        fwd_rd = ram_rd;
        for (int i = 0; i < 4; i++) begin
            if (wr_lane[i] && (idx_q == rd_idx)) begin
                fwd_rd[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pend      <= 1'b0;
            write_q   <= 1'b0;
            idx_q     <= '0;
            wait_cnt  <= 4'd0;
            HREADYOUT <= 1'b1;
            HRESP     <= HRESP_OKAY;
            HRDATA    <= 32'd0;
            err_count <= 8'd0;
        end else begin
            pend <= 1'b0;
            case (state)
                S_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state     <= S_IDLE;
                        pend      <= 1'b1;
                        HREADYOUT <= 1'b1;
                        if (!write_q) begin
                            HRDATA <= fwd_rd;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ERR1: begin
                    state     <= S_ERR2;
                    HREADYOUT <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    HRESP <= HRESP_OKAY;
                    if (accept) begin
                        idx_q   <= addr_idx;
                        write_q <= HWRITE;
                        if (!in_range) begin
                            state     <= S_ERR1;
                            HREADYOUT <= 1'b0;
                            HRESP     <= HRESP_ERROR;
                            if (err_count != 8'hFF) begin
                                err_count <= err_count + 8'd1;
                            end
                        end else if (WAIT_STATES > 0) begin
                            state     <= S_WAIT;
                            HREADYOUT <= 1'b0;
                            wait_cnt  <= WAIT_LAST;
                        end else begin
                            pend <= 1'b1;
                            if (!HWRITE) begin
                                HRDATA <= fwd_rd;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // A trigger coinciding with an acknowledge starts a fresh request, so trigger wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_req <= 1'b0;
        end else if (dma_trigger) begin
            dma_req <= 1'b1;
        end else if (req_ack && dma_req) begin
            dma_req <= 1'b0;
        end
    end

endmodule
